// File: rtl/gmem_scheduler.sv
// gmem_scheduler: round-robin global-memory arbiter with burst quota, lock and zero-bubble handoff
module gmem_scheduler #(
    parameter int NUM_CORES = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CORES-1:0]         request,
    input  logic [NUM_CORES-1:0]         lock,
    output logic [NUM_CORES-1:0]         grant_oh,
    output logic [$clog2(NUM_CORES)-1:0] grant_id,
    output logic                         grant_valid,
    output logic                         handoff
);
    localparam int W  = $clog2(NUM_CORES);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t         state;
    logic [W-1:0]   ptr;
    logic [CW-1:0]  cnt;
    logic           own;
    logic           quota;
    logic           release_o;
    logic [W-1:0]   ptr_next;
    logic [W-1:0]   start;
    logic [NUM_CORES-1:0] mask;
    logic [W-1:0]   win;

    // grant_oh is zero in IDLE, so clearing it from request yields both search masks
    always_comb begin
        own       = state == OWN;
        quota     = cnt == CW'(MAX_BURST);
        mask      = request & ~grant_oh;
        release_o = own && (!request[grant_id] || (quota && !lock[grant_id] && |mask));
        ptr_next  = grant_id == W'(NUM_CORES - 1) ? '0 : grant_id + 1'b1;
        start     = own ? ptr_next : ptr;
    end

    // first set bit of mask scanning upward from start, wrapping around
    always_comb begin
        win = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--)
            if (mask[(int'(start) + k) % NUM_CORES]) win = W'((int'(start) + k) % NUM_CORES);
    end

    // ownership FSM with registered grant outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            cnt         <= '0;
            grant_oh    <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            handoff     <= 1'b0;
        end else begin
            handoff <= 1'b0;
            if (!own || release_o) begin
                if (own) ptr <= ptr_next;
                if (|mask) begin
                    state       <= OWN;
                    grant_oh    <= NUM_CORES'(1) << win;
                    grant_id    <= win;
                    grant_valid <= 1'b1;
                    handoff     <= 1'b1;
                    cnt         <= CW'(1);
                end else begin
                    state       <= IDLE;
                    grant_oh    <= '0;
                    grant_id    <= '0;
                    grant_valid <= 1'b0;
                    cnt         <= '0;
                end
            end else begin
                cnt <= !quota ? cnt + 1'b1 : lock[grant_id] ? cnt : CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_gmem_scheduler.sv
// tb_gmem_scheduler: directed and randomized checks of gmem_scheduler against a reference model
module tb_gmem_scheduler;
    localparam int N  = 4;
    localparam int MB = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] request = '0;
    logic [N-1:0] lock = '0;
    logic [N-1:0] grant_oh;
    logic [1:0]   grant_id;
    logic         grant_valid;
    logic         handoff;

    int compared = 0;
    int mismatched = 0;

    int m_owner = -1;
    int m_ptr = 0;
    int m_cnt = 0;
    int m_hand = 0;

    gmem_scheduler #(.NUM_CORES(N), .MAX_BURST(MB)) dut (
        .clk(clk),
        .reset(reset),
        .request(request),
        .lock(lock),
        .grant_oh(grant_oh),
        .grant_id(grant_id),
        .grant_valid(grant_valid),
        .handoff(handoff)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int first_from(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++)
            if (m[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // reference: one clock edge of the arbitration rules
    task automatic model(input logic [N-1:0] r, input logic [N-1:0] l);
        logic [N-1:0] others;
        bit rel;
        m_hand = 0;
        if (m_owner < 0) begin
            if (r != 0) begin
                m_owner = first_from(r, m_ptr);
                m_cnt = 1;
                m_hand = 1;
            end
        end else begin
            others = r;
            others[m_owner] = 1'b0;
            rel = !r[m_owner] || (m_cnt == MB && !l[m_owner] && others != 0);
            if (rel) begin
                m_ptr = (m_owner + 1) % N;
                if (others != 0) begin
                    m_owner = first_from(others, m_ptr);
                    m_cnt = 1;
                    m_hand = 1;
                end else begin
                    m_owner = -1;
                    m_cnt = 0;
                end
            end else if (m_cnt < MB) m_cnt++;
            else if (l[m_owner]) m_cnt = MB;
            else m_cnt = 1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":grant_oh"}, grant_oh, m_owner < 0 ? 0 : 1 << m_owner);
        chk({tag, ":grant_id"}, grant_id, m_owner < 0 ? 0 : m_owner);
        chk({tag, ":grant_valid"}, grant_valid, m_owner >= 0);
        chk({tag, ":handoff"}, handoff, m_hand);
        chk({tag, ":ptr"}, dut.ptr, m_ptr);
        chk({tag, ":onehot"}, $onehot0(grant_oh), 1);
        if (m_owner >= 0) chk({tag, ":cnt"}, dut.cnt, m_cnt);
    endtask

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input string tag);
        request = r;
        lock = l;
        @(posedge clk);
        model(r, l);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        request = '0;
        lock = '0;
        @(posedge clk);
        #1;
        m_owner = -1;
        m_ptr = 0;
        m_cnt = 0;
        m_hand = 0;
        check_all("reset");
        chk("reset:cnt", dut.cnt, 0);
        reset = 1'b0;
    endtask

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] l;

        // drop handoff: core1 for two cycles, then core2 with no bubble
        do_reset();
        step(4'b0110, 4'b0000, "drop");
        chk("drop:first_owner", grant_id, 1);
        step(4'b0110, 4'b0000, "drop");
        step(4'b0100, 4'b0000, "drop");
        chk("drop:second_owner", grant_id, 2);
        chk("drop:nobubble", handoff, 1);
        chk("drop:ptr", dut.ptr, 2);

        // idle return keeps ptr, then a fresh grant from IDLE
        step(4'b0000, 4'b0000, "idle");
        chk("idle:valid", grant_valid, 0);
        step(4'b0001, 4'b0000, "idle");
        chk("idle:owner", grant_id, 0);
        chk("idle:ptr", dut.ptr, 3);

        // quota preemption alternating core0/core1
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(4'b0011, 4'b0000, "quota");
            chk("quota:owner", grant_id, (i / 4) % 2);
            chk("quota:handoff", handoff, i % 4 == 0);
        end

        // lock holds core0 past the quota, non-owner lock bits ignored
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(4'b1111, 4'b0101, "lock");
            chk("lock:owner", grant_id, 0);
        end
        chk("lock:sat", dut.cnt, MB);
        step(4'b1111, 4'b0100, "unlock");
        chk("unlock:owner", grant_id, 1);

        // lone requester renews its quota window
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(4'b1000, 4'b0000, "lone");
            chk("lone:cnt", dut.cnt, i % 4 + 1);
            chk("lone:handoff", handoff, i == 0);
        end

        // asynchronous reset in the middle of a core2 grant
        do_reset();
        step(4'b0100, 4'b0000, "async");
        step(4'b0100, 4'b0000, "async");
        #2;
        reset = 1'b1;
        #1;
        chk("async:grant_oh", grant_oh, 0);
        chk("async:valid", grant_valid, 0);
        chk("async:id", grant_id, 0);
        m_owner = -1;
        m_ptr = 0;
        m_cnt = 0;
        m_hand = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(4'b0100, 4'b0000, "async_resume");
        chk("async_resume:owner", grant_id, 2);

        // randomized traffic with owners tending to hold their request
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r = N'($urandom_range(0, 15));
            l = N'($urandom_range(0, 15)) & N'($urandom_range(0, 15));
            if (m_owner >= 0 && $urandom_range(0, 4) != 0) r[m_owner] = 1'b1;
            if ($urandom_range(0, 149) == 0) do_reset();
            else step(r, l, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/gmem_scheduler.md
GMEM_SCHEDULER -- requirements
Module: gmem_scheduler

Interface
REQ-001 Parameter NUM_CORES, default 16: number of requesting cores; legal values are 2 or more.
REQ-002 Parameter MAX_BURST, default 4: grant quota in cycles before a preemption check; legal values are 1 or more.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port request, input, NUM_CORES: per-core global-memory access request; bit i belongs to core i.
REQ-006 Port lock, input, NUM_CORES: per-core non-preemptible hold; honoured only for the current owner while its request is high.
REQ-007 Port grant_oh, output, NUM_CORES: registered one-hot grant, or all-zero when there is no owner.
REQ-008 Port grant_id, output, $clog2(NUM_CORES): binary index of the owner; 0 when there is no owner.
REQ-009 Port grant_valid, output, 1: equals OR of grant_oh.
REQ-010 Port handoff, output, 1: one-cycle pulse in the first cycle of every new grant, including a grant from IDLE.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE (no owner) and OWN (exactly one owner o).
REQ-012 The block SHALL hold a round-robin pointer ptr (0..NUM_CORES-1) and a burst counter cnt of width $clog2(MAX_BURST+1).
REQ-013 Winner selection SHALL be the first set bit of the search mask, scanning ptr, ptr+1, ... modulo NUM_CORES.
REQ-014 Winner selection SHALL be combinational; the resulting grant SHALL be registered and visible in the cycle after the edge.
REQ-015 In IDLE with any request bit set, the next edge SHALL grant the winner, set cnt=1, enter OWN and pulse handoff.
REQ-016 In IDLE with request all-zero, the block SHALL remain in IDLE and all outputs SHALL stay zero.
REQ-017 In OWN, the owner SHALL be released when request[o]=0 (drop).
REQ-018 In OWN, the owner SHALL also be released when all of the following hold: cnt==MAX_BURST, lock[o]=0, and request has a bit set other than o (quota preemption).
REQ-019 On release, ptr SHALL become (o+1) mod NUM_CORES, and the search mask SHALL be request with bit o cleared.
REQ-020 On release, if the search mask is non-zero, the winner SHALL be granted at the same edge with cnt=1 and a handoff pulse (zero-bubble handoff).
REQ-021 On release, if the search mask is zero, the block SHALL go to IDLE, and grant_oh SHALL be zero in the next cycle.
REQ-022 When not released and cnt<MAX_BURST, cnt SHALL increment by 1.
REQ-023 When not released, cnt==MAX_BURST and no other core requests, the owner SHALL keep the grant and cnt SHALL reload to 1 (new quota window).
REQ-024 When not released, cnt==MAX_BURST and lock[o]=1, the owner SHALL keep the grant and cnt SHALL saturate at MAX_BURST.
REQ-025 A lock bit of any non-owner SHALL have no effect.
REQ-026 lock[o]=1 with request[o]=0 SHALL be treated as a drop.
REQ-027 ptr SHALL change only on release; a grant from IDLE SHALL not modify ptr.
REQ-028 grant_oh SHALL never have more than one bit set, and grant_id SHALL always match grant_oh.
REQ-029 Simultaneous drop by the owner and a new request from another core SHALL hand off at that same edge.

Reset
REQ-030 While reset is high, the outputs SHALL be: grant_oh=0, grant_id=0, grant_valid=0, handoff=0.
REQ-031 While reset is high, the internal state SHALL be: state=IDLE, ptr=0, cnt=0.
REQ-032 Reset asserted mid-grant SHALL clear the grant immediately, without waiting for a clock edge.
REQ-033 After reset deassertion, arbitration SHALL resume from ptr=0.

Verification (NUM_CORES=4, MAX_BURST=4)
REQ-034 Drop handoff: after reset, request=4'b0110 -> core1 granted on the next edge with handoff=1; core1 drops after 2 cycles -> core2 granted at that same edge, no bubble, ptr=2.
REQ-035 Quota preemption: request=4'b0011 held constant -> grant alternates core0 x4 cycles, core1 x4, core0 x4; each transition pulses handoff.
REQ-036 Lock: core0 owns with lock[0]=1 and request=4'b1111 for 10 cycles -> core0 held for all 10 cycles, cnt saturates at 4; clear lock[0] -> core1 granted at the next edge.
REQ-037 Lone requester: request=4'b1000 for 9 cycles -> core3 granted continuously, handoff only in the first cycle, cnt follows 1,2,3,4,1,2,...
REQ-038 Idle return: the owner drops with request=0 -> grant_valid=0 the next cycle; a new request=4'b0001 -> core0 granted, and ptr is unchanged from its value after the drop.
REQ-039 Async reset: assert reset between edges during a core2 grant -> grant_oh=0 immediately; after release with request=4'b0100 -> core2 granted at the next edge.
